// File: rtl/swap_pkg.sv
// Shared constants for the compare/swap pipeline.
// Mode encodings and default widths used by the block and its bench.
package swap_pkg;

    localparam logic MODE_SWAP = 1'b0;
    localparam logic MODE_SORT = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_reg.sv
// Valid/ready register slice with a generic payload.
// Accepts a new beat whenever empty or draining in the same cycle.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Ready is held low while in reset so nothing is accepted then.
    assign in_ready = !rst && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cmp_swap_pipe.sv
// Two-stage compare/swap pipeline with a saturating swap counter.
// S1 holds the raw operands; the decision is made on the way into S2.
module cmp_swap_pipe
    import swap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_swapped,
    output logic [CNT_W-1:0] swap_cnt
);

    localparam int PW = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic          s1_valid;
    logic [PW-1:0] s1_data;
    logic          s2_ready;
    logic [PW-1:0] s2_in;
    logic [PW-1:0] s2_data;

    logic             s1_mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             exch;

    pipe_reg #(.W(PW)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({mode, in_a, in_b}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign s1_mode = s1_data[PW-1];
    assign s1_a    = s1_data[2*WIDTH-1:WIDTH];
    assign s1_b    = s1_data[WIDTH-1:0];

    always_comb begin
        exch = 1'b0;
        unique case (s1_mode)
            MODE_SWAP: exch = 1'b1;
            MODE_SORT: exch = (s1_a > s1_b);
            default:   exch = 1'b0;
        endcase
    end

    assign s2_in = exch ? {1'b1, s1_b, s1_a} : {1'b0, s1_a, s1_b};

    pipe_reg #(.W(PW)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_swapped = s2_data[PW-1];
    assign out_a       = s2_data[2*WIDTH-1:WIDTH];
    assign out_b       = s2_data[WIDTH-1:0];

    // Count only delivered exchanged pairs; stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_cnt <= '0;
        end else if (out_valid && out_ready && out_swapped && (swap_cnt != '1)) begin
            swap_cnt <= swap_cnt + CNT_ONE;
        end
    end

endmodule
